sisc_mem_resp: RTL and testbench

SISC_MEM_RESP -- requirements
Module: sisc_mem_resp

---
 rtl/sisc_mem_resp.sv | 118 +++++++++++
 tb/tb_sisc_mem_resp.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sisc_mem_resp.sv
// sisc_mem_resp -- single-outstanding memory responder with programmable wait states.
//
// Accepts one request at a time from a control FSM, waits WAIT cycles, then
// acknowledges with a one-cycle ack. Writes are committed at the edge that
// closes the ack cycle; reads present the addressed word on rdata during ack
// and hold it afterwards.
//
// Parameters:
//   AW    address width (storage holds 2^AW words)
//   DW    data word width
//   WAIT  wait-state cycles between accept and ack, 0..15
// Ports:
//   clk    clock, rising edge
//   rst_f  asynchronous active-high reset
//   req    request valid, held until ack
//   we     1 = write, 0 = read (sampled with req)
//   addr   word address (sampled with req)
//   wdata  write data (sampled with req)
//   ack    one-cycle completion pulse
//   rdata  read data, valid in the ack cycle of a read, held otherwise
//   busy   high from accept until ack (inclusive)
module sisc_mem_resp #(
    parameter int AW   = 8,
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          busy
);

    localparam logic [3:0] WAIT_C = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAITST = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic          latch_en;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;

    // Not reset: contents survive rst_f.
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        latch_en = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    latch_en = 1'b1;
                    cnt_nx   = WAIT_C;
                    state_nx = (WAIT == 0) ? RESP : WAITST;
                end
            end
            WAITST: begin
                cnt_nx = cnt - 4'd1;
                // Counter shows 1 in the last wait cycle; <= guards a stray 0.
                if (cnt <= 4'd1) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request capture; inputs are ignored outside the IDLE accept edge.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (latch_en) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Write lands at the edge closing RESP; a reset aborts it because the
    // state register is already forced out of RESP.
    always_ff @(posedge clk) begin
        if (!rst_f && state == RESP && we_q) mem[addr_q] <= wdata_q;
    end

    // Holding register keeps the last read word once ack drops.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f)                       rdata_q <= '0;
        else if (state == RESP && !we_q) rdata_q <= mem[addr_q];
    end

    assign ack   = (state == RESP);
    assign busy  = (state != IDLE);
    assign rdata = (ack && !we_q) ? mem[addr_q] : rdata_q;

endmodule

// File: tb/tb_sisc_mem_resp.sv
// tb_sisc_mem_resp -- self-checking bench for sisc_mem_resp.
//
// Two instances share clk/rst_f: u0 with WAIT=2 and u1 with WAIT=0. A
// transaction-level model (accept cycle + fixed latency, plain array memory)
// predicts ack/busy/rdata and is compared every falling edge; directed
// scenarios add literal expectations on top.
module tb_sisc_mem_resp;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [1:0]  req, we, ack, busy;
    logic [7:0]  addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sisc_mem_resp #(.AW(8), .DW(32), .WAIT(2)) u0 (
        .clk(clk), .rst_f(rst_f), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0])
    );

    sisc_mem_resp #(.AW(8), .DW(32), .WAIT(0)) u1 (
        .clk(clk), .rst_f(rst_f), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1])
    );

    function automatic int wt(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic [31:0] pat(input int i, input logic [7:0] a);
        return {8'hA5, 8'(i), a, ~a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    // cyc indexes the interval after each rising edge. A request accepted at
    // edge a is busy from interval a and acks in interval a+WAIT.
    int          cyc = 0;
    bit          m_pend [2];
    int          m_acc  [2];
    bit          m_we   [2];
    logic [7:0]  m_addr [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_rd   [2];
    logic [31:0] m_mem  [2][256];

    always @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            for (int i = 0; i < 2; i++) begin
                m_pend[i] <= 1'b0;
                m_rd[i]   <= '0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 2; i++) begin
                if (m_pend[i]) begin
                    if (cyc == m_acc[i] + wt(i)) begin
                        m_pend[i] <= 1'b0;
                        if (m_we[i]) m_mem[i][m_addr[i]] <= m_wd[i];
                        else         m_rd[i] <= m_mem[i][m_addr[i]];
                    end
                end else if (req[i]) begin
                    m_pend[i] <= 1'b1;
                    m_acc[i]  <= cyc + 1;
                    m_we[i]   <= we[i];
                    m_addr[i] <= addr[i];
                    m_wd[i]   <= wdata[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic        e_ack;
            logic [31:0] e_rd;
            e_ack = m_pend[i] && (cyc == m_acc[i] + wt(i));
            e_rd  = (e_ack && !m_we[i]) ? m_mem[i][m_addr[i]] : m_rd[i];
            chk($sformatf("ack[%0d]@%0d", i, cyc), ack[i], e_ack);
            chk($sformatf("busy[%0d]@%0d", i, cyc), busy[i], m_pend[i]);
            chk($sformatf("rdata[%0d]@%0d", i, cyc), rdata[i], e_rd);
        end
    end

    // ---------------- stimulus ----------------
    // Issue one request; b2b raises req in the current timestep (no idle gap
    // on the bench side), corrupt changes addr/wdata in the first wait cycle.
    task automatic do_req(input int i, input bit w, input logic [7:0] a,
                          input logic [31:0] d, input bit b2b, input bit corrupt,
                          output int lat, output int nbusy, output logic [31:0] rd);
        if (!b2b) @(negedge clk);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        lat = 0; nbusy = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy[i]) nbusy++;
            if (corrupt && lat == 1) begin
                addr[i]  = 8'hFF;
                wdata[i] = 32'h0;
            end
            if (ack[i]) break;
        end
        rd = rdata[i];
        chk($sformatf("ack_seen[%0d]", i), ack[i], 1'b1);
        req[i] = 1'b0;
    endtask

    initial begin
        int          lat, nb;
        logic [31:0] rd;
        logic [5:0]  ackv;
        logic [31:0] rdv [6];

        rst_f = 1'b1;
        req   = '0;
        we    = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_ack0",   ack[0],   1'b0);
        chk("rst_busy0",  busy[0],  1'b0);
        chk("rst_rdata0", rdata[0], 32'h0);
        chk("rst_busy1",  busy[1],  1'b0);
        rst_f = 1'b0;

        // Fill both arrays with a known pattern.
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 256; a++)
                do_req(i, 1'b1, 8'(a), pat(i, 8'(a)), 1'b0, 1'b0, lat, nb, rd);

        // Write then read 0x05 on the WAIT=2 instance.
        do_req(0, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0, 1'b0, lat, nb, rd);
        chk("wr05_lat",   lat, 3);
        chk("wr05_busy",  nb,  3);
        chk("wr05_rdata", rd,  32'h0);
        do_req(0, 1'b0, 8'h05, 32'h0, 1'b0, 1'b0, lat, nb, rd);
        chk("rd05_lat",   lat, 3);
        chk("rd05_rdata", rd,  32'hDEADBEEF);
        @(negedge clk);
        chk("rd05_hold",  rdata[0], 32'hDEADBEEF);
        chk("rd05_noack", ack[0],   1'b0);

        // WAIT=0, req held continuously: reads of 0x00 then 0x01.
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ackv[k] = ack[1];
            rdv[k]  = rdata[1];
            if (k == 0) addr[1] = 8'h01;
            if (k == 2) req[1]  = 1'b0;
        end
        chk("b2b_ackpat", ackv, 6'b000101);
        chk("b2b_rd0",    rdv[0], 32'hA50100FF);
        chk("b2b_hold",   rdv[1], 32'hA50100FF);
        chk("b2b_rd1",    rdv[2], 32'hA50101FE);

        // Inputs changed during the wait of a write must be ignored.
        do_req(0, 1'b1, 8'h10, 32'h12345678, 1'b0, 1'b1, lat, nb, rd);
        do_req(0, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, lat, nb, rd);
        chk("ign_rd10", rd, 32'h12345678);
        do_req(0, 1'b0, 8'hFF, 32'h0, 1'b0, 1'b0, lat, nb, rd);
        chk("ign_rdFF", rd, 32'hA500FF00);

        // Reset mid-cycle during the wait of a write to 0x20.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h20; wdata[0] = 32'hAAAA5555;
        @(negedge clk);
        chk("rst_pre_busy", busy[0], 1'b1);
        #2 rst_f = 1'b1; req[0] = 1'b0;
        #1;
        chk("arst_ack0",   ack[0],   1'b0);
        chk("arst_busy0",  busy[0],  1'b0);
        chk("arst_rdata0", rdata[0], 32'h0);
        chk("arst_rdata1", rdata[1], 32'h0);
        #1 rst_f = 1'b0;
        // Request raised right after reset release is accepted on the next edge.
        do_req(0, 1'b0, 8'h20, 32'h0, 1'b1, 1'b0, lat, nb, rd);
        chk("post_rst_lat", lat, 3);
        chk("rd20_kept",    rd,  32'hA50020DF);

        // Write then immediate read at the top address.
        do_req(0, 1'b1, 8'hFF, 32'hCAFEF00D, 1'b0, 1'b0, lat, nb, rd);
        do_req(0, 1'b0, 8'hFF, 32'h0, 1'b1, 1'b0, lat, nb, rd);
        chk("wrapFF_lat", lat, 4);
        chk("wrapFF_rd",  rd,  32'hCAFEF00D);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
